// File: rtl/ws2812_pkg.sv
// Shared state/owner encodings and bus widths for the WS2812 LED byte RAM arbiter.
package ws2812_pkg;

    localparam int unsigned BANK_W      = 4;
    localparam int unsigned BANK_ADDR_W = 9;
    localparam int unsigned RAM_ADDR_W  = 13;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned BURST_W     = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant0 = 2'b01,
        StGrant1 = 2'b10
    } arb_state_e;

    localparam logic [1:0] OwnerNone = 2'b00;
    localparam logic [1:0] OwnerRq0  = 2'b01;
    localparam logic [1:0] OwnerRq1  = 2'b10;

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ws2812_bank_decode.sv
// Bank index to one-hot vector; all-zero when the enable is low.
module ws2812_bank_decode
    import ws2812_pkg::*;
#(
    parameter int unsigned NumBanks = 16
) (
    input  logic [BANK_W-1:0]   bank_i,
    input  logic                en_i,
    output logic [NumBanks-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned b = 0; b < NumBanks; b++) begin
            onehot_o[b] = en_i && (bank_i == BANK_W'(b));
        end
    end

endmodule

// File: rtl/ws2812_ram_arbiter.sv
// Two-requester arbiter for the 16-bank LED byte RAM with bounded bursts.
// Define WS2812_ARB_FIXED_PRIO_EN to give rq0 fixed priority instead of round-robin.
module ws2812_ram_arbiter
    import ws2812_pkg::*;
#(
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned NUM_BANKS = 16
) (
    input  logic                   clk_sb,
    input  logic                   reset,
    input  logic                   rq0_req,
    input  logic                   rq0_lock,
    input  logic                   rq0_we,
    input  logic [RAM_ADDR_W-1:0]  rq0_addr,
    input  logic [DATA_W-1:0]      rq0_wdata,
    output logic                   rq0_gnt,
    output logic                   rq0_rvalid,
    output logic [DATA_W-1:0]      rq0_rdata,
    input  logic                   rq1_req,
    input  logic                   rq1_lock,
    input  logic                   rq1_we,
    input  logic [RAM_ADDR_W-1:0]  rq1_addr,
    input  logic [DATA_W-1:0]      rq1_wdata,
    output logic                   rq1_gnt,
    output logic                   rq1_rvalid,
    output logic [DATA_W-1:0]      rq1_rdata,
    output logic [NUM_BANKS-1:0]   ram_sel,
    output logic [NUM_BANKS-1:0]   ram_we,
    output logic [BANK_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic [1:0]             owner
);

    localparam logic [BURST_W-1:0] BurstMax = BURST_W'(MAX_BURST);

    arb_state_e           state_q, state_d;
    logic                 last_owner_q, last_owner_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [BURST_W-1:0]   burst_inc;
    logic                 limit_hit;

    logic                 acc0, acc1, acc;
    logic [RAM_ADDR_W-1:0] acc_addr;
    logic                 acc_we;
    logic [DATA_W-1:0]    acc_wdata;

    logic [NUM_BANKS-1:0]   ram_sel_q, ram_sel_d;
    logic [NUM_BANKS-1:0]   ram_we_q, ram_we_d;
    logic [BANK_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]      ram_wdata_q, ram_wdata_d;
    // Read tag pipeline: stage 1 tracks the RAM strobe, stage 2 the data return.
    logic rd_v1_q, rd_v1_d, rd_own1_q, rd_own1_d;
    logic rd_v2_q, rd_v2_d, rd_own2_q, rd_own2_d;

    assign acc0 = (state_q == StGrant0) && rq0_req;
    assign acc1 = (state_q == StGrant1) && rq1_req;
    assign acc  = acc0 | acc1;

    assign burst_inc = sat_inc(burst_cnt_q);
    assign limit_hit = (burst_inc >= BurstMax);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            StIdle: begin
                burst_cnt_d = '0;
`ifdef WS2812_ARB_FIXED_PRIO_EN
                if (rq0_req) begin
                    state_d = StGrant0;
                end else if (rq1_req) begin
                    state_d = StGrant1;
                end
`else
                if (rq0_req && rq1_req) begin
                    state_d = last_owner_q ? StGrant0 : StGrant1;
                end else if (rq0_req) begin
                    state_d = StGrant0;
                end else if (rq1_req) begin
                    state_d = StGrant1;
                end
`endif
            end
            StGrant0: begin
                if (rq0_req) begin
                    burst_cnt_d = burst_inc;
                end
                if (!rq0_lock) begin
                    if (!rq0_req || (limit_hit && rq1_req)) begin
                        state_d      = rq1_req ? StGrant1 : StIdle;
                        last_owner_d = 1'b0;
                        burst_cnt_d  = '0;
                    end else if (limit_hit) begin
                        burst_cnt_d = '0;
                    end
                end
            end
            StGrant1: begin
                if (rq1_req) begin
                    burst_cnt_d = burst_inc;
                end
`ifdef WS2812_ARB_FIXED_PRIO_EN
                // rq0 preempts as soon as rq1 is not locked; no burst limit for rq1.
                if (!rq1_lock && (!rq1_req || rq0_req)) begin
                    state_d      = rq0_req ? StGrant0 : StIdle;
                    last_owner_d = 1'b1;
                    burst_cnt_d  = '0;
                end
`else
                if (!rq1_lock) begin
                    if (!rq1_req || (limit_hit && rq0_req)) begin
                        state_d      = rq0_req ? StGrant0 : StIdle;
                        last_owner_d = 1'b1;
                        burst_cnt_d  = '0;
                    end else if (limit_hit) begin
                        burst_cnt_d = '0;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_addr  = rq0_addr;
        acc_we    = rq0_we;
        acc_wdata = rq0_wdata;
        if (state_q == StGrant1) begin
            acc_addr  = rq1_addr;
            acc_we    = rq1_we;
            acc_wdata = rq1_wdata;
        end
    end

    ws2812_bank_decode #(
        .NumBanks (NUM_BANKS)
    ) u_sel_dec (
        .bank_i   (acc_addr[RAM_ADDR_W-1:BANK_ADDR_W]),
        .en_i     (acc),
        .onehot_o (ram_sel_d)
    );

    ws2812_bank_decode #(
        .NumBanks (NUM_BANKS)
    ) u_we_dec (
        .bank_i   (acc_addr[RAM_ADDR_W-1:BANK_ADDR_W]),
        .en_i     (acc & acc_we),
        .onehot_o (ram_we_d)
    );

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (acc) begin
            ram_addr_d  = acc_addr[BANK_ADDR_W-1:0];
            ram_wdata_d = acc_wdata;
        end
        rd_v1_d   = acc & ~acc_we;
        rd_own1_d = acc1;
        rd_v2_d   = rd_v1_q;
        rd_own2_d = rd_own1_q;
    end

    always_ff @(posedge clk_sb) begin
        if (reset) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
            ram_sel_q    <= '0;
            ram_we_q     <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rd_v1_q      <= 1'b0;
            rd_own1_q    <= 1'b0;
            rd_v2_q      <= 1'b0;
            rd_own2_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            ram_sel_q    <= ram_sel_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_v1_q      <= rd_v1_d;
            rd_own1_q    <= rd_own1_d;
            rd_v2_q      <= rd_v2_d;
            rd_own2_q    <= rd_own2_d;
        end
    end

    always_comb begin
        case (state_q)
            StGrant0: owner = OwnerRq0;
            StGrant1: owner = OwnerRq1;
            default:  owner = OwnerNone;
        endcase
    end

    assign rq0_gnt    = (state_q == StGrant0);
    assign rq1_gnt    = (state_q == StGrant1);
    assign rq0_rvalid = rd_v2_q & ~rd_own2_q;
    assign rq1_rvalid = rd_v2_q & rd_own2_q;
    assign rq0_rdata  = ram_rdata;
    assign rq1_rdata  = ram_rdata;
    assign ram_sel    = ram_sel_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_ws2812_ram_arbiter.sv
// Directed bench for ws2812_ram_arbiter with a behavioural RAM read model.
module tb_ws2812_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rq0_req, rq0_lock, rq0_we;
    logic [12:0] rq0_addr;
    logic [7:0]  rq0_wdata;
    logic        rq0_gnt, rq0_rvalid;
    logic [7:0]  rq0_rdata;
    logic        rq1_req, rq1_lock, rq1_we;
    logic [12:0] rq1_addr;
    logic [7:0]  rq1_wdata;
    logic        rq1_gnt, rq1_rvalid;
    logic [7:0]  rq1_rdata;
    logic [15:0] ram_sel, ram_we;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [1:0]  owner;

    int total = 0;
    int bad = 0;
    int n0, n1;
    logic [16:0] g0, g1, rv0, rv1;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];

    always #5 clk = ~clk;

    ws2812_ram_arbiter #(
        .MAX_BURST (4),
        .NUM_BANKS (16)
    ) dut (
        .clk_sb     (clk),
        .reset      (reset),
        .rq0_req    (rq0_req),
        .rq0_lock   (rq0_lock),
        .rq0_we     (rq0_we),
        .rq0_addr   (rq0_addr),
        .rq0_wdata  (rq0_wdata),
        .rq0_gnt    (rq0_gnt),
        .rq0_rvalid (rq0_rvalid),
        .rq0_rdata  (rq0_rdata),
        .rq1_req    (rq1_req),
        .rq1_lock   (rq1_lock),
        .rq1_we     (rq1_we),
        .rq1_addr   (rq1_addr),
        .rq1_wdata  (rq1_wdata),
        .rq1_gnt    (rq1_gnt),
        .rq1_rvalid (rq1_rvalid),
        .rq1_rdata  (rq1_rdata),
        .ram_sel    (ram_sel),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .owner      (owner)
    );

    // RAM content is a fixed function of the full 13-bit address.
    function automatic logic [7:0] ram_fn(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h53;
    endfunction

    function automatic logic [3:0] oh_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always @(posedge clk) ram_rdata <= ram_fn({oh_idx(ram_sel), ram_addr});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        rq0_req = 1'b0; rq0_lock = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0;
        rq1_req = 1'b0; rq1_lock = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;
        tick();
        tick();
        chk("rst_gnt", {30'd0, rq0_gnt, rq1_gnt}, 0);
        chk("rst_rvalid", {30'd0, rq0_rvalid, rq1_rvalid}, 0);
        chk("rst_sel", ram_sel, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_owner", owner, 0);
        reset = 1'b0;

        // Single read by rq0
        rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 13'h0A05;
        tick();
        chk("rd_gnt0", rq0_gnt, 1);
        chk("rd_gnt1", rq1_gnt, 0);
        chk("rd_owner", owner, 1);
        tick();
        chk("rd_sel", ram_sel, 16'h0020);
        chk("rd_addr", ram_addr, 9'h005);
        chk("rd_we", ram_we, 0);
        rq0_req = 1'b0;
        tick();
        chk("rd_rvalid0", rq0_rvalid, 1);
        chk("rd_rdata0", rq0_rdata, 8'h5C);
        chk("rd_rvalid1", rq1_rvalid, 0);
        chk("rd_sel_idle", ram_sel, 0);
        tick();
        chk("rd_owner_idle", owner, 0);
        chk("rd_rvalid0_once", rq0_rvalid, 0);

        // Single write by rq1
        rq1_req = 1'b1; rq1_we = 1'b1; rq1_addr = 13'h1FFF; rq1_wdata = 8'hA7;
        tick();
        chk("wr_gnt1", rq1_gnt, 1);
        chk("wr_gnt0", rq0_gnt, 0);
        chk("wr_owner", owner, 2);
        tick();
        chk("wr_sel", ram_sel, 16'h8000);
        chk("wr_we", ram_we, 16'h8000);
        chk("wr_addr", ram_addr, 9'h1FF);
        chk("wr_wdata", ram_wdata, 8'hA7);
        rq1_req = 1'b0; rq1_we = 1'b0;
        tick();
        chk("wr_we_off", ram_we, 0);
        tick();
        chk("wr_no_rvalid", {30'd0, rq0_rvalid, rq1_rvalid}, 0);

        // Simultaneous requests from reset: rq0 first, then rq1 with no idle state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rq0_req = 1'b1; rq0_addr = 13'h0010;
        rq1_req = 1'b1; rq1_addr = 13'h0020;
        tick();
        chk("sim_c1", {30'd0, rq0_gnt, rq1_gnt}, 2'b10);
        tick();
        chk("sim_c2", {30'd0, rq0_gnt, rq1_gnt}, 2'b10);
        tick();
        chk("sim_c3", {30'd0, rq0_gnt, rq1_gnt}, 2'b10);
        tick();
        chk("sim_c4", {30'd0, rq0_gnt, rq1_gnt}, 2'b10);
        rq0_req = 1'b0;
        tick();
        chk("sim_c5", {30'd0, rq0_gnt, rq1_gnt}, 2'b01);
        chk("sim_c5_owner", owner, 2);
        tick();
        chk("sim_c6", {30'd0, rq0_gnt, rq1_gnt}, 2'b01);
        tick();
        chk("sim_c7", {30'd0, rq0_gnt, rq1_gnt}, 2'b01);
        tick();
        chk("sim_c8", {30'd0, rq0_gnt, rq1_gnt}, 2'b01);
        rq1_req = 1'b0;
        tick();
        chk("sim_c9_owner", owner, 0);
        tick();

        // Burst limit of 4 with rq1 waiting; rdata routed per issuer
        g0 = 17'h07F1E; g1 = 17'h000E0; rv0 = 17'h0FC78; rv1 = 17'h00180;
        n0 = 0; n1 = 0;
        for (int cyc = 0; cyc <= 16; cyc++) begin
            chk("burst_gnt0", rq0_gnt, g0[cyc]);
            chk("burst_gnt1", rq1_gnt, g1[cyc]);
            chk("burst_rvalid0", rq0_rvalid, rv0[cyc]);
            chk("burst_rvalid1", rq1_rvalid, rv1[cyc]);
            if (rv0[cyc]) chk("burst_rdata0", rq0_rdata, q0.pop_front());
            if (rv1[cyc]) chk("burst_rdata1", rq1_rdata, q1.pop_front());
            rq0_req  = (cyc <= 13);
            rq1_req  = (cyc <= 6);
            rq0_addr = 13'h0100 + 13'(n0);
            rq1_addr = 13'h0A00 + 13'(n1);
            if (rq0_req && g0[cyc]) begin
                q0.push_back(ram_fn(rq0_addr));
                n0++;
            end
            if (rq1_req && g1[cyc]) begin
                q1.push_back(ram_fn(rq1_addr));
                n1++;
            end
            tick();
        end
        chk("burst_rq0_count", n0, 10);

        // Lock holds the grant well past the burst limit
        rq0_req = 1'b1; rq0_lock = 1'b1; rq0_addr = 13'h0300;
        tick();
        rq1_req = 1'b1; rq1_addr = 13'h0400;
        for (int i = 1; i <= 70; i++) begin
            chk("lock_hold", {30'd0, rq0_gnt, rq1_gnt}, 2'b10);
            rq0_addr = 13'h0300 + 13'(i);
            tick();
        end
        chk("lock_c71", {30'd0, rq0_gnt, rq1_gnt}, 2'b10);
        rq0_req = 1'b0; rq0_lock = 1'b0;
        tick();
        chk("lock_handover", {30'd0, rq0_gnt, rq1_gnt}, 2'b01);
        chk("lock_owner", owner, 2);
        tick();
        rq1_req = 1'b0;
        tick();
        chk("lock_idle", owner, 0);

        // Reset mid-burst: leave last_owner at rq0 first so its reset value matters
        rq0_req = 1'b1; rq0_addr = 13'h0050;
        tick();
        rq0_req = 1'b1;
        tick();
        rq0_req = 1'b0;
        tick();
        rq0_req = 1'b1; rq0_addr = 13'h0A05; rq0_wdata = 8'h33;
        tick();
        chk("rstm_gnt0", rq0_gnt, 1);
        tick();
        chk("rstm_sel_pre", ram_sel, 16'h0020);
        reset = 1'b1; rq0_req = 1'b0;
        tick();
        reset = 1'b0;
        chk("rstm_gnt", {30'd0, rq0_gnt, rq1_gnt}, 0);
        chk("rstm_rvalid", {30'd0, rq0_rvalid, rq1_rvalid}, 0);
        chk("rstm_sel", ram_sel, 0);
        chk("rstm_we", ram_we, 0);
        chk("rstm_addr", ram_addr, 0);
        chk("rstm_wdata", ram_wdata, 0);
        chk("rstm_owner", owner, 0);
        rq0_req = 1'b1; rq0_addr = 13'h0060;
        rq1_req = 1'b1; rq1_addr = 13'h0070;
        tick();
        chk("rstm_rvalid_late", {30'd0, rq0_rvalid, rq1_rvalid}, 0);
        chk("rstm_first_win", {30'd0, rq0_gnt, rq1_gnt}, 2'b10);
        rq0_req = 1'b0; rq1_req = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
